spi_frame_transmitter: RTL

- SPI master that streams one full frame from frame memory to an LCD-style SPI display port.
- Command set is the one our SPI frame receiver decodes: CAS 0x2A, RAS 0x2B, MWR 0x2C.
- Serves as the loopback/test source for the receiver and as the driver for an external SPI panel.
- Reads BGR555 words from frame memory, converts them to RGB565, and shifts them MSB-first over CSn/SCLK/SDO/DC.

---
 rtl/spi_frame_transmitter.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_frame_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_transmitter
// Purpose  : SPI mode-0 master that streams one frame from frame memory as
//            CAS/RAS/MWR transactions, converting BGR555 words to RGB565.
//            Optional back-to-back framing is enabled by SPI_TX_LOOP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spi_frame_transmitter #(
    parameter int WIDTH   = 240,
    parameter int HEIGHT  = 160,
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 4
) (
    input  logic        IwClk,
    input  logic        IwRstn,
    input  logic        IwStart,
    output logic        OwBusy,
    output logic        OwDone,
    output logic [15:0] ObFrameMemReadAddr,
    input  logic [15:0] IbFrameMemReadData,
    output logic        OwCSn,
    output logic        OwSCLK,
    output logic        OwSDO,
    output logic        OwDC
);

    localparam int          NPIX      = WIDTH * HEIGHT;
    localparam logic [19:0] LAST_PIX  = 20'(NPIX - 1);
    localparam logic [15:0] LAST_ADDR = 16'(NPIX - 1);
    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST  = 16'(CS_GAP - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CAS_CMD = 3'd1;
    localparam logic [2:0] S_CAS_DAT = 3'd2;
    localparam logic [2:0] S_RAS_CMD = 3'd3;
    localparam logic [2:0] S_RAS_DAT = 3'd4;
    localparam logic [2:0] S_MWR_CMD = 3'd5;
    localparam logic [2:0] S_MWR_DAT = 3'd6;
    localparam logic [2:0] S_FINISH  = 3'd7;

    localparam logic [2:0] P_SETUP = 3'd0;
    localparam logic [2:0] P_LOW   = 3'd1;
    localparam logic [2:0] P_HIGH  = 3'd2;
    localparam logic [2:0] P_HOLD  = 3'd3;
    localparam logic [2:0] P_GAP   = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [2:0]  phase_q, phase_d;
    logic [15:0] div_q, div_d;
    logic [19:0] bit_q, bit_d;
    logic [19:0] pix_q, pix_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] shift_q, shift_d;
    logic [14:0] fetch_q;
    logic        loop_q, loop_d;

    logic        csn_q, csn_d;
    logic        sclk_q, sclk_d;
    logic        sdo_q, sdo_d;
    logic        dc_q, dc_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        xfer_d;

    logic        last_bit;
    logic [15:0] div_last;
    logic        bit15_unused;

    assign bit15_unused = IbFrameMemReadData[15];

    function automatic logic [15:0] to_rgb565(input logic [14:0] w);
        return {w[4:0], w[9:5], w[9], w[14:10]};
    endfunction

    // Shift-register image for the first word of a transaction, MSB at bit 31.
    function automatic logic [31:0] load_word(input logic [2:0] st, input logic [14:0] pix);
        logic [31:0] v;
        v = 32'h0;
        case (st)
            S_CAS_CMD: v = {8'h2A, 24'h0};
            S_CAS_DAT: v = {16'h0000, 16'(WIDTH - 1)};
            S_RAS_CMD: v = {8'h2B, 24'h0};
            S_RAS_DAT: v = {16'h0000, 16'(HEIGHT - 1)};
            S_MWR_CMD: v = {8'h2C, 24'h0};
            S_MWR_DAT: v = {to_rgb565(pix), 16'h0000};
            default:   v = 32'h0;
        endcase
        return v;
    endfunction

    assign div_last = (phase_q == P_GAP) ? GAP_LAST : DIV_LAST;

    always_comb begin : p_last_bit
        last_bit = 1'b0;
        case (state_q)
            S_CAS_CMD, S_RAS_CMD, S_MWR_CMD: last_bit = (bit_q == 20'd7);
            S_CAS_DAT, S_RAS_DAT:            last_bit = (bit_q == 20'd31);
            S_MWR_DAT:                       last_bit = (bit_q == 20'd15) && (pix_q == LAST_PIX);
            default:                         last_bit = 1'b0;
        endcase
    end

    always_ff @(posedge IwClk or negedge IwRstn) begin : p_state
        if (!IwRstn) begin
            state_q <= S_IDLE;
            phase_q <= P_SETUP;
            div_q   <= 16'd0;
            bit_q   <= 20'd0;
            pix_q   <= 20'd0;
            addr_q  <= 16'd0;
            shift_q <= 32'd0;
            fetch_q <= 15'd0;
            loop_q  <= 1'b0;
            csn_q   <= 1'b1;
            sclk_q  <= 1'b0;
            sdo_q   <= 1'b0;
            dc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            pix_q   <= pix_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            fetch_q <= IbFrameMemReadData[14:0];
            loop_q  <= loop_d;
            csn_q   <= csn_d;
            sclk_q  <= sclk_d;
            sdo_q   <= sdo_d;
            dc_q    <= dc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin : p_next
        state_d = state_q;
        phase_d = phase_q;
        div_d   = div_q;
        bit_d   = bit_q;
        pix_d   = pix_q;
        addr_d  = addr_q;
        shift_d = shift_q;
        loop_d  = loop_q;
        case (state_q)
            S_IDLE: begin
                if (IwStart) begin
                    state_d = S_CAS_CMD;
                    phase_d = P_SETUP;
                    div_d   = 16'd0;
                    bit_d   = 20'd0;
                    pix_d   = 20'd0;
                    addr_d  = 16'd0;
                    shift_d = load_word(S_CAS_CMD, fetch_q);
                end
            end
            S_FINISH: begin
                phase_d = P_SETUP;
                div_d   = 16'd0;
                bit_d   = 20'd0;
                pix_d   = 20'd0;
                addr_d  = 16'd0;
                loop_d  = 1'b0;
                if (loop_q) begin
                    state_d = S_CAS_CMD;
                    shift_d = load_word(S_CAS_CMD, fetch_q);
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                if (div_q != div_last) begin
                    div_d = div_q + 16'd1;
                end else begin
                    div_d = 16'd0;
                    case (phase_q)
                        P_SETUP: phase_d = P_LOW;
                        P_LOW:   phase_d = P_HIGH;
                        P_HIGH: begin
                            if (last_bit) begin
                                phase_d = P_HOLD;
                            end else begin
                                phase_d = P_LOW;
                                // Pixel boundary: next word is already prefetched, so no SCLK stall.
                                if (state_q == S_MWR_DAT && bit_q == 20'd15) begin
                                    bit_d   = 20'd0;
                                    pix_d   = pix_q + 20'd1;
                                    shift_d = load_word(S_MWR_DAT, fetch_q);
                                    if (addr_q != LAST_ADDR) begin
                                        addr_d = addr_q + 16'd1;
                                    end
                                end else begin
                                    bit_d   = bit_q + 20'd1;
                                    shift_d = {shift_q[30:0], 1'b0};
                                end
                            end
                        end
                        P_HOLD: phase_d = P_GAP;
                        default: begin
                            state_d = state_q + 3'd1;
                            phase_d = P_SETUP;
                            bit_d   = 20'd0;
                            shift_d = load_word(state_q + 3'd1, fetch_q);
                            if (state_q == S_MWR_CMD && addr_q != LAST_ADDR) begin
                                addr_d = addr_q + 16'd1;
                            end
                            if (state_q == S_MWR_DAT) begin
`ifdef SPI_TX_LOOP_EN
                                loop_d = IwStart;
`else
                                loop_d = 1'b0;
`endif
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    // Outputs are decoded from next state and registered, so the pins never glitch.
    always_comb begin : p_out
        xfer_d = (state_d != S_IDLE) && (state_d != S_FINISH);
        csn_d  = !(xfer_d && (phase_d == P_LOW || phase_d == P_HIGH || phase_d == P_HOLD));
        sclk_d = xfer_d && (phase_d == P_HIGH);
        sdo_d  = xfer_d && shift_d[31];
        dc_d   = (state_d == S_CAS_DAT || state_d == S_RAS_DAT || state_d == S_MWR_DAT)
                 && (phase_d != P_GAP);
        done_d = (state_d == S_FINISH);
        busy_d = xfer_d || ((state_d == S_FINISH) && loop_d);
    end

    assign ObFrameMemReadAddr = addr_q;
    assign OwCSn  = csn_q;
    assign OwSCLK = sclk_q;
    assign OwSDO  = sdo_q;
    assign OwDC   = dc_q;
    assign OwBusy = busy_q;
    assign OwDone = done_q;

endmodule
`default_nettype wire
